fp_exp_arbiter: RTL and testbench

FP_EXP_ARBITER -- requirements
Module: fp_exp_arbiter

---
 rtl/fp_ci_pkg.sv | 14 +
 rtl/fp_rr_arb.sv | 32 +++
 rtl/fp_exp_arbiter.sv | 114 +++++++++++
 tb/tb_fp_exp_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_ci_pkg.sv
// Shared constants and the tag type used by the exp-unit front end.
// Holds FP_WIDTH, the default exp latency and the {valid, id} tag.
package fp_ci_pkg;

    localparam int FP_WIDTH    = 32;
    localparam int EXP_LATENCY = 17;
    localparam int TAG_ID_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp_rr_arb.sv
// Combinational round-robin picker.
// Search starts at the requester after ptr and wraps.
module fp_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] id
);

    int  idx;
    logic found;

    // first valid requester after ptr, in wrap-around order
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_exp_arbiter.sv
// Shares one fixed-latency exp unit among NUM_REQ requesters.
// Optional FP_EXP_ARB_INFLIGHT_EN adds an in-flight counter port.
module fp_exp_arbiter
    import fp_ci_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = EXP_LATENCY
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [FP_WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [FP_WIDTH-1:0]         exp_data,
    output logic                        exp_clk_en,
    input  logic [FP_WIDTH-1:0]         exp_result,
    output logic [NUM_REQ-1:0]          rsp_valid,
`ifdef FP_EXP_ARB_INFLIGHT_EN
    output logic [FP_WIDTH-1:0]         rsp_data,
    output logic [5:0]                  inflight
`else
    output logic [FP_WIDTH-1:0]         rsp_data
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_id;
    logic               active;
    logic               issue;
    logic               retire;
    tag_t               tag_in;
    tag_t               pipe [LATENCY];
    tag_t               tag_out;

    fp_rr_arb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .id    (grant_id)
    );

    assign active     = clk_en && !reset;
    assign req_ready  = active ? grant : '0;
    assign issue      = |req_ready;
    assign exp_clk_en = clk_en;
    assign rsp_data   = exp_result;
    assign tag_out    = pipe[LATENCY-1];
    assign retire     = active && tag_out.valid;

    // steer the granted operand to the exp unit
    always_comb begin
        exp_data = req_data[int'(grant_id)*FP_WIDTH +: FP_WIDTH];
        tag_in.valid = issue;
        tag_in.id    = TAG_ID_W'(grant_id);
    end

    // decode the retiring tag into a one-hot strobe
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = retire && (tag_out.id == TAG_ID_W'(i));
        end
    end

    // round-robin pointer follows the last issued id
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= IW'(NUM_REQ-1);
        end else if (issue) begin
            ptr <= grant_id;
        end
    end

    // tag pipeline mirrors the exp unit and freezes with clk_en
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else if (clk_en) begin
            pipe[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

`ifdef FP_EXP_ARB_INFLIGHT_EN
    logic [5:0] cnt;

    assign inflight = cnt;

    // count operations between issue and retire
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clk_en) begin
            unique case ({issue, retire})
                2'b10:   cnt <= cnt + 6'd1;
                2'b01:   cnt <= cnt - 6'd1;
                default: cnt <= cnt;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fp_exp_arbiter.sv
// Scoreboard bench for fp_exp_arbiter with a behavioural exp unit.
// Define FP_EXP_ARB_INFLIGHT_EN to also check the inflight counter.
module tb_fp_exp_arbiter;

    localparam int N = 4;
    localparam int L = 17;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
        int          cyc;
    } sb_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            clk_en = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [31:0]     exp_data;
    logic            exp_clk_en;
    logic [31:0]     exp_result;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
`ifdef FP_EXP_ARB_INFLIGHT_EN
    logic [5:0]      inflight;
    int              max_infl = 0;
`endif

    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   mptr = N-1;
    sb_t  q [$];
    int   gseq [$];
    int   lat_by_id [N];
    logic [31:0] dat_by_id [N];
    logic [31:0] xpipe [L];

    sb_t          e;
    logic [N-1:0] eg;
    int           gid;

    fp_exp_arbiter #(
        .NUM_REQ (N),
        .LATENCY (L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .exp_data   (exp_data),
        .exp_clk_en (exp_clk_en),
        .exp_result (exp_result),
        .rsp_valid  (rsp_valid),
`ifdef FP_EXP_ARB_INFLIGHT_EN
        .rsp_data   (rsp_data),
        .inflight   (inflight)
`else
        .rsp_data   (rsp_data)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fexp(input logic [31:0] x);
        if (x == 32'h3F80_0000) return 32'h402D_F854;
        return {x[15:0], x[31:16]} ^ 32'h1234_5678;
    endfunction

    // behavioural exp unit: fixed latency, advances on exp_clk_en
    always @(posedge clk) begin
        if (exp_clk_en) begin
            xpipe[0] <= exp_data;
            for (int i = 1; i < L; i++) xpipe[i] <= xpipe[i-1];
        end
    end
    assign exp_result = fexp(xpipe[L-1]);

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    // reference model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        check("exp_clk_en", 64'(exp_clk_en), 64'(clk_en));
        if (reset) begin
            check("rst_ready", 64'(req_ready), 64'd0);
            check("rst_rsp", 64'(rsp_valid), 64'd0);
            q.delete();
            gseq.delete();
            mptr = N-1;
        end else if (!clk_en) begin
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_rsp", 64'(rsp_valid), 64'd0);
        end else begin
`ifdef FP_EXP_ARB_INFLIGHT_EN
            check("inflight", 64'(inflight), 64'(q.size()));
            if (int'(inflight) > max_infl) max_infl = int'(inflight);
`endif
            if (q.size() > 0 && q[0].due == en_cnt) begin
                e = q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(1 << e.id));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                lat_by_id[e.id] = cyc - e.cyc;
                dat_by_id[e.id] = rsp_data;
            end else begin
                check("rsp_idle", 64'(rsp_valid), 64'd0);
            end
            eg  = '0;
            gid = -1;
            for (int k = 1; k <= N; k++) begin
                if (gid < 0 && req_valid[(mptr + k) % N]) gid = (mptr + k) % N;
            end
            if (gid >= 0) eg[gid] = 1'b1;
            check("grant", 64'(req_ready), 64'(eg));
            if (gid >= 0) begin
                check("exp_data", 64'(exp_data), 64'(req_data[32*gid +: 32]));
                q.push_back('{id: gid, data: fexp(req_data[32*gid +: 32]),
                              due: en_cnt + L, cyc: cyc});
                gseq.push_back(gid);
                mptr = gid;
            end
            en_cnt++;
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // hold each valid until granted, then drop it
    task automatic drain_reqs();
        logic [N-1:0] g;
        for (int i = 0; i < 80 && req_valid != '0; i++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
        end
        check("drain_timeout", 64'(req_valid), 64'd0);
    endtask

    task automatic set_req(input int id, input logic [31:0] d);
        req_data[32*id +: 32] = d;
        req_valid[id] = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [N-1:0] g;
        logic [N-1:0] rv;
        tick(2);
        reset = 1'b0;
        tick(1);

        // single operand, known result, fixed latency
        lat_by_id[0] = 0;
        set_req(0, 32'h3F80_0000);
        drain_reqs();
        tick(L + 2);
        check("t1_lat", 64'(lat_by_id[0]), 64'd17);
        check("t1_data", 64'(dat_by_id[0]), 64'h402D_F854);

        // full demand after reset: strict rotation 0..3
        pulse_reset();
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'h4000_0000 + i;
        req_valid = '1;
        tick(8);
        req_valid = '0;
        check("t2_count", 64'(gseq.size()), 64'd8);
        for (int i = 0; i < 8 && i < gseq.size(); i++)
            check("t2_order", 64'(gseq[i]), 64'(i % N));
        tick(L + 4);

        // stall of 5 disabled cycles, 6 cycles after issue
        lat_by_id[1] = 0;
        set_req(1, 32'h3F00_0000);
        drain_reqs();
        tick(5);
        clk_en = 1'b0;
        set_req(2, 32'h3E80_0000);
        tick(5);
        clk_en = 1'b1;
        drain_reqs();
        tick(L + 4);
        check("t3_lat", 64'(lat_by_id[1]), 64'd22);

        // reset discards in-flight work; then req 0 wins first
        set_req(0, 32'h1111_1111);
        set_req(1, 32'h2222_2222);
        set_req(2, 32'h3333_3333);
        drain_reqs();
        tick(7);
        pulse_reset();
        tick(L + 4);
        req_valid = '1;
        tick(4);
        req_valid = '0;
        check("t4_first", 64'(gseq.size() > 0 ? gseq[0] : -1), 64'd0);
        tick(L + 4);

        // after a grant to 2, requester 3 precedes requester 1
        set_req(2, 32'h5555_0000);
        drain_reqs();
        n = gseq.size();
        set_req(1, 32'h6666_0000);
        set_req(3, 32'h7777_0000);
        drain_reqs();
        check("t5_first", 64'(gseq.size() > n ? gseq[n] : -1), 64'd3);
        check("t5_second", 64'(gseq.size() > n+1 ? gseq[n+1] : -1), 64'd1);
        tick(L + 4);

        // continuous single-requester issue
        set_req(0, 32'h3F80_0000);
        tick(30);
        req_valid = '0;
        tick(L + 4);
`ifdef FP_EXP_ARB_INFLIGHT_EN
        check("t6_max", 64'(max_infl), 64'd17);
        check("t6_zero", 64'(inflight), 64'd0);
`endif

        // random traffic with random clock gating
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            rv = req_valid & ~g;
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    req_data[32*i +: 32] = $urandom;
                end
            end
            req_valid = rv;
            clk_en = ($urandom_range(0, 4) != 0);
        end
        clk_en = 1'b1;
        drain_reqs();
        tick(L + 4);
        check("final_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
